// File: rtl/rvm_fetch_unit_if.sv
// rvm_fetch_unit_if: bundles the instruction-memory read port, the redirect
// request and the instruction-buffer drain port of the fetch unit.
//
// Signals:
//   mem_addr/mem_c_en/mem_b_en   fetch request towards instruction memory
//   mem_rdata/mem_error          response, valid in the cycle after acceptance
//   mem_stall                    request not accepted this cycle
//   i_redirect/i_redirect_pc     flush and restart fetch at a new address
//   o_valid/o_instr/o_pc/o_error buffer head presented to the consumer
//   i_ready                      consumer accepts the head
//
// Handshake semantics: the memory accepts a request in every cycle where
// mem_c_en=1 and mem_stall=0; a stalled request keeps mem_c_en and mem_addr
// unchanged. The head entry transfers in every cycle where o_valid=1 and
// i_ready=1; o_valid never depends on i_ready, and while o_valid=1 the head
// fields stay stable until the transfer or a redirect.
//
// Modports: master = fetch unit, slave = memory + control FSM side.
interface rvm_fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_c_en;
  logic [3:0]  mem_b_en;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        mem_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_error;
  logic        i_ready;

  modport master (
    output mem_addr, mem_c_en, mem_b_en,
    input  mem_rdata, mem_error, mem_stall,
    input  i_redirect, i_redirect_pc,
    output o_valid, o_instr, o_pc, o_error,
    input  i_ready
  );

  modport slave (
    input  mem_addr, mem_c_en, mem_b_en,
    output mem_rdata, mem_error, mem_stall,
    output i_redirect, i_redirect_pc,
    input  o_valid, o_instr, o_pc, o_error,
    output i_ready
  );
endinterface

// File: rtl/rvm_fetch_unit.sv
// rvm_fetch_unit: instruction fetch sequencer for the multi-cycle RISC-V core.
// Issues pipelined single-outstanding reads to instruction memory, queues the
// returned words in a small show-ahead buffer drained by the control FSM, and
// flushes/restarts on redirect (branches, jumps, traps). A bus error halts
// fetching until the next redirect.
//
// Parameters:
//   RESET_PC  first fetch address after reset (word aligned)
//   DEPTH     instruction buffer entries (power of two, 1..8)
//   PC_STEP   fetch address increment per accepted request
//
// Ports:
//   clk        system clock
//   resetn     asynchronous, active-low reset
//   bus        rvm_fetch_unit_if.master (memory port, redirect, buffer head)
//   dbg_state  current FSM state: 0=POST_RESET, 1=FETCH, 2=HALTED
module rvm_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                    clk,
  input  logic                    resetn,
  rvm_fetch_unit_if.master        bus,
  output logic [1:0]              dbg_state
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_POST_RESET = 2'd0,
    ST_FETCH      = 2'd1,
    ST_HALTED     = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       fetch_pc;
  logic              inflight;
  logic [31:0]       inflight_pc;

  logic [31:0]       buf_instr [DEPTH];
  logic [31:0]       buf_pc    [DEPTH];
  logic              buf_err   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;
  logic              accept;
  logic              has_space;
  logic [CNT_W:0]    occ_now;
  logic [CNT_W:0]    occ_limit;
  logic [31:0]       redirect_target;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign redirect_target = bus.i_redirect_pc & 32'hFFFF_FFFC;

  // Head outputs come straight from storage and are forced to 0 when empty.
  assign bus.o_valid = (count != '0);
  assign bus.o_instr = bus.o_valid ? buf_instr[rd_ptr] : 32'h0;
  assign bus.o_pc    = bus.o_valid ? buf_pc[rd_ptr]    : 32'h0;
  assign bus.o_error = bus.o_valid ? buf_err[rd_ptr]   : 1'b0;
  assign pop         = bus.o_valid & bus.i_ready;

  // Issue only when the buffer can take every word already owed to it plus
  // this one. A same-cycle pop counts as freed space. Once a request is
  // presented, this condition stays true through any stall: the response in
  // flight lands in the buffer and no new request is accepted, so occupancy
  // plus in-flight can only shrink. mem_c_en/mem_addr therefore hold steady
  // during a stall without extra state.
  assign occ_now     = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign occ_limit   = (CNT_W + 1)'(DEPTH) + {{CNT_W{1'b0}}, pop};
  assign has_space   = occ_now < occ_limit;

  assign bus.mem_c_en = (state == ST_FETCH) & has_space;
  assign bus.mem_addr = bus.mem_c_en ? fetch_pc : 32'h0;
  assign bus.mem_b_en = 4'b1111;
  assign accept       = bus.mem_c_en & ~bus.mem_stall;

  // A response is kept only while fetching: a redirect in the response cycle
  // drops it, and anything returning after an error (state HALTED) is stale.
  assign push = inflight & ~bus.i_redirect & (state == ST_FETCH);

  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_POST_RESET;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (bus.i_redirect) begin
      state    <= ST_FETCH;
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        ST_POST_RESET: state <= ST_FETCH;
        ST_FETCH:      if (push && bus.mem_error) state <= ST_HALTED;
        default:       state <= state;
      endcase
      if (accept) begin
        fetch_pc    <= fetch_pc + PC_STEP;
        inflight_pc <= fetch_pc;
      end
      inflight <= accept;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: it is only visible through the count-qualified
  // head outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= bus.mem_rdata;
      buf_pc[wr_ptr]    <= inflight_pc;
      buf_err[wr_ptr]   <= bus.mem_error;
    end
  end

endmodule

// File: tb/tb_rvm_fetch_unit.sv
// tb_rvm_fetch_unit: self-checking bench for rvm_fetch_unit (DEPTH=2,
// RESET_PC=0x100). A memory driver answers accepted requests one cycle later;
// a reference model tracks program order and the issue rule and checks every
// cycle, while directed tasks check the cycle-exact scenarios.
module tb_rvm_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] dbg_state;

  rvm_fetch_unit_if fu_if ();

  rvm_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH(DEPTH),
    .PC_STEP(PC_STEP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(fu_if),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  // stimulus knobs applied at the start of each cycle
  logic        k_resetn = 1'b0;
  logic        k_stall  = 1'b0;
  logic        k_ready  = 1'b1;
  logic        k_redir  = 1'b0;
  logic [31:0] k_rpc    = 32'h0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  // memory driver
  logic        resp_pend = 1'b0;
  logic [31:0] resp_addr = 32'h0;

  // reference model
  logic [31:0] exp_q[$];
  logic [31:0] req_pc     = RESET_PC;
  logic        m_pend     = 1'b0;
  logic [31:0] m_pend_pc  = 32'h0;
  logic        m_fetching = 1'b0;
  logic        m_halted   = 1'b0;

  // last sampled outputs
  logic        s_c_en;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_instr;
  logic [31:0] s_pc;
  logic        s_err;

  initial begin
    fu_if.mem_rdata     = 32'h0;
    fu_if.mem_error     = 1'b0;
    fu_if.mem_stall     = 1'b0;
    fu_if.i_redirect    = 1'b0;
    fu_if.i_redirect_pc = 32'h0;
    fu_if.i_ready       = 1'b1;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1ns later, check
  // against the model, then advance the model.
  task automatic tick();
    logic exp_valid;
    logic exp_c_en;
    logic pop;
    logic acc;
    int   occ;
    @(negedge clk);
    resetn              = k_resetn;
    fu_if.mem_stall     = k_stall;
    fu_if.i_ready       = k_ready;
    fu_if.i_redirect    = k_redir;
    fu_if.i_redirect_pc = k_rpc;
    if (resp_pend) begin
      fu_if.mem_rdata = word_of(resp_addr);
      fu_if.mem_error = (resp_addr == err_addr);
    end else begin
      fu_if.mem_rdata = $urandom;
      fu_if.mem_error = 1'($urandom_range(0, 1));
    end
    #1;
    s_c_en  = fu_if.mem_c_en;
    s_addr  = fu_if.mem_addr;
    s_valid = fu_if.o_valid;
    s_instr = fu_if.o_instr;
    s_pc    = fu_if.o_pc;
    s_err   = fu_if.o_error;

    exp_valid = k_resetn && (exp_q.size() > 0);
    pop       = exp_valid && k_ready;
    occ       = exp_q.size() + int'(m_pend) - int'(pop);
    exp_c_en  = k_resetn && m_fetching && !m_halted && (occ < DEPTH);

    checks++;
    if (s_c_en !== exp_c_en)
      begin errors++; $display("FAIL mem_c_en: got %b expected %b at %0t", s_c_en, exp_c_en, $time); end
    checks++;
    if (s_c_en === 1'b1) begin
      if (s_addr !== req_pc)
        begin errors++; $display("FAIL mem_addr: got %h expected %h at %0t", s_addr, req_pc, $time); end
    end else if (s_addr !== 32'h0)
      begin errors++; $display("FAIL mem_addr_idle: got %h expected 0 at %0t", s_addr, $time); end
    checks++;
    if (fu_if.mem_b_en !== 4'b1111)
      begin errors++; $display("FAIL mem_b_en: got %h expected f", fu_if.mem_b_en); end
    checks++;
    if (s_valid !== exp_valid)
      begin errors++; $display("FAIL o_valid: got %b expected %b at %0t", s_valid, exp_valid, $time); end
    if (exp_valid && s_valid === 1'b1) begin
      checks++;
      if (s_pc !== exp_q[0] || s_instr !== word_of(exp_q[0]) || s_err !== (exp_q[0] == err_addr))
        begin
          errors++;
          $display("FAIL head: got pc=%h instr=%h err=%b expected pc=%h instr=%h err=%b at %0t",
                   s_pc, s_instr, s_err, exp_q[0], word_of(exp_q[0]), (exp_q[0] == err_addr), $time);
        end
    end else if (s_valid !== 1'b1) begin
      checks++;
      if ({s_instr, s_pc, s_err} !== 65'h0)
        begin errors++; $display("FAIL head_idle: got instr=%h pc=%h err=%b expected zeros", s_instr, s_pc, s_err); end
    end

    acc = (s_c_en === 1'b1) && !k_stall;
    if (!k_resetn) begin
      exp_q.delete();
      m_pend     = 1'b0;
      req_pc     = RESET_PC;
      m_halted   = 1'b0;
      m_fetching = 1'b0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (k_redir) begin
        exp_q.delete();
        m_pend   = 1'b0;
        req_pc   = k_rpc & 32'hFFFF_FFFC;
        m_halted = 1'b0;
      end else begin
        if (m_pend && !m_halted) begin
          exp_q.push_back(m_pend_pc);
          if (m_pend_pc == err_addr) m_halted = 1'b1;
        end
        m_pend    = acc;
        m_pend_pc = req_pc;
        if (acc) req_pc = req_pc + PC_STEP;
      end
      m_fetching = 1'b1;
    end
    resp_pend = acc && k_resetn;
    resp_addr = s_addr;
    k_redir   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the DUT in reset for two cycles; the next tick is cycle 0.
  task automatic do_reset();
    k_resetn = 1'b0;
    k_stall  = 1'b0;
    k_ready  = 1'b1;
    k_redir  = 1'b0;
    run(2);
    k_resetn = 1'b1;
  endtask

  task automatic test_reset();
    err_addr = 32'hFFFF_FFFF;
    do_reset();
    checks++;
    if (s_c_en !== 1'b0 || s_addr !== 32'h0 || s_valid !== 1'b0 || dbg_state !== 2'd0)
      begin errors++; $display("FAIL reset_values: got c_en=%b addr=%h valid=%b state=%0d expected 0,0,0,0", s_c_en, s_addr, s_valid, dbg_state); end
    tick(); // cycle 0
    checks++;
    if (s_c_en !== 1'b0)
      begin errors++; $display("FAIL cycle0_no_request: got c_en=%b expected 0", s_c_en); end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 3) begin
        checks++;
        if (s_c_en !== 1'b1 || s_addr !== RESET_PC + 32'(4 * (c - 1)))
          begin errors++; $display("FAIL first_requests: cycle %0d got c_en=%b addr=%h expected 1 %h", c, s_c_en, s_addr, RESET_PC + 32'(4 * (c - 1))); end
      end
      if (c >= 3) begin
        checks++;
        if (s_valid !== 1'b1 || s_pc !== RESET_PC + 32'(4 * (c - 3)))
          begin errors++; $display("FAIL first_pops: cycle %0d got valid=%b pc=%h expected 1 %h", c, s_valid, s_pc, RESET_PC + 32'(4 * (c - 3))); end
      end
    end
  endtask

  task automatic test_stall();
    err_addr = 32'hFFFF_FFFF;
    do_reset();
    run(2); // cycles 0,1: 0x100 accepted in cycle 1
    k_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (s_c_en !== 1'b1 || s_addr !== 32'h104)
        begin errors++; $display("FAIL stall_hold: got c_en=%b addr=%h expected 1 00000104", s_c_en, s_addr); end
    end
    k_stall = 1'b0;
    tick();
    checks++;
    if (s_addr !== 32'h104)
      begin errors++; $display("FAIL stall_release: got addr=%h expected 00000104", s_addr); end
    tick();
    checks++;
    if (s_addr !== 32'h108)
      begin errors++; $display("FAIL stall_next: got addr=%h expected 00000108", s_addr); end
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h104)
      begin errors++; $display("FAIL stall_order: got valid=%b pc=%h expected 1 00000104", s_valid, s_pc); end
  endtask

  task automatic test_backpressure();
    err_addr = 32'hFFFF_FFFF;
    do_reset();
    k_ready = 1'b0;
    run(8);
    checks++;
    if (s_c_en !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h100)
      begin errors++; $display("FAIL buffer_full: got c_en=%b valid=%b pc=%h expected 0 1 00000100", s_c_en, s_valid, s_pc); end
    k_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'h100 + 32'(4 * c))
        begin errors++; $display("FAIL drain_rate: step %0d got valid=%b pc=%h expected 1 %h", c, s_valid, s_pc, 32'h100 + 32'(4 * c)); end
    end
  endtask

  task automatic test_redirect();
    err_addr = 32'hFFFF_FFFF;
    do_reset();
    k_ready = 1'b0;
    run(6);
    k_ready = 1'b1;
    tick(); // pops 0x100, 0x108 accepted
    k_ready = 1'b0;
    k_redir = 1'b1;
    k_rpc   = 32'h0000_2003;
    tick(); // redirect while 0x108 response arrives and 0x104 is buffered
    checks++;
    if (s_c_en !== 1'b0)
      begin errors++; $display("FAIL redirect_full: got c_en=%b expected 0", s_c_en); end
    k_ready = 1'b1;
    tick();
    checks++;
    if (s_c_en !== 1'b1 || s_addr !== 32'h2000 || s_valid !== 1'b0)
      begin errors++; $display("FAIL redirect_first: got c_en=%b addr=%h valid=%b expected 1 00002000 0", s_c_en, s_addr, s_valid); end
    tick();
    checks++;
    if (s_valid !== 1'b0)
      begin errors++; $display("FAIL redirect_flushed: got valid=%b pc=%h expected 0", s_valid, s_pc); end
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h2000)
      begin errors++; $display("FAIL redirect_head: got valid=%b pc=%h expected 1 00002000", s_valid, s_pc); end
  endtask

  task automatic test_error();
    err_addr = 32'h0000_0108;
    do_reset();
    run(5); // cycles 0..4, error response in cycle 4
    tick(); // cycle 5
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h108 || s_err !== 1'b1 || s_c_en !== 1'b0 || dbg_state !== 2'd2)
      begin errors++; $display("FAIL error_entry: got valid=%b pc=%h err=%b c_en=%b state=%0d expected 1 00000108 1 0 2", s_valid, s_pc, s_err, s_c_en, dbg_state); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (s_c_en !== 1'b0 || s_valid !== 1'b0)
        begin errors++; $display("FAIL halted_quiet: got c_en=%b valid=%b expected 0 0", s_c_en, s_valid); end
    end
    k_redir = 1'b1;
    k_rpc   = 32'h0000_0040;
    tick();
    tick();
    checks++;
    if (s_c_en !== 1'b1 || s_addr !== 32'h40 || dbg_state !== 2'd1)
      begin errors++; $display("FAIL halted_resume: got c_en=%b addr=%h state=%0d expected 1 00000040 1", s_c_en, s_addr, dbg_state); end
    run(4);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    err_addr = 32'hFFFF_FFFF;
    do_reset();
    run(4);
    k_redir = 1'b1;
    k_rpc   = 32'hFFFF_FFF8;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (s_c_en !== 1'b1 || s_addr !== exp_addr[c])
        begin errors++; $display("FAIL wrap_addr: step %0d got c_en=%b addr=%h expected 1 %h", c, s_c_en, s_addr, exp_addr[c]); end
    end
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'hFFFF_FFF8)
      begin errors++; $display("FAIL wrap_head: got valid=%b pc=%h expected 1 fffffff8", s_valid, s_pc); end
    run(4);
  endtask

  task automatic test_mid_reset();
    err_addr = 32'hFFFF_FFFF;
    do_reset();
    run(5);
    k_resetn = 1'b0;
    tick(); // reset asserted at the falling edge, sampled before any rising edge
    checks++;
    if (s_c_en !== 1'b0 || s_valid !== 1'b0 || dbg_state !== 2'd0)
      begin errors++; $display("FAIL async_reset: got c_en=%b valid=%b state=%0d expected 0 0 0", s_c_en, s_valid, dbg_state); end
    tick();
    k_resetn = 1'b1;
    run(2);
    checks++;
    if (s_c_en !== 1'b1 || s_addr !== RESET_PC)
      begin errors++; $display("FAIL reset_restart: got c_en=%b addr=%h expected 1 %h", s_c_en, s_addr, RESET_PC); end
  endtask

  task automatic test_random();
    int start_pops;
    logic did_redir;
    err_addr = 32'h0000_0140;
    do_reset();
    start_pops = pops;
    for (int c = 0; c < 2000; c++) begin
      k_resetn  = ($urandom_range(0, 299) != 0);
      k_stall   = ($urandom_range(0, 3) == 0);
      k_ready   = ($urandom_range(0, 9) < 7);
      k_redir   = ($urandom_range(0, 39) == 0);
      k_rpc     = 32'($urandom_range(256, 1023));
      did_redir = k_redir && k_resetn;
      tick();
      if (did_redir) err_addr = 32'($urandom_range(64, 255)) << 2;
    end
    k_resetn = 1'b1;
    checks++;
    if (pops - start_pops < 200)
      begin errors++; $display("FAIL random_progress: got %0d pops expected at least 200", pops - start_pops); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_backpressure();
    test_redirect();
    test_error();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvm_fetch_unit.md
# rvm_fetch_unit

Parametrised instruction fetch sequencer for the multi-cycle RISC-V core. It takes over the fetch and PC-increment steps from the control FSM. It runs its own fetch FSM with a configurable reset vector, and issues pipelined reads to the instruction memory port while honouring stall and error. Fetched words go into a small instruction buffer that the control FSM drains through a valid/ready handshake. A redirect input flushes the unit for branches, jumps and traps.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2: instruction buffer entries; power of two, 1..8.
- PC_STEP, 4: fetch address increment per accepted request.
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- mem_addr  out  32  fetch address; 0 when mem_c_en=0.
- mem_c_en  out  1  read request.
- mem_b_en  out  4  constant 4'b1111.
- mem_rdata  in  32  read data, valid in the cycle after request acceptance.
- mem_error  in  1  bus error, qualified like mem_rdata.
- mem_stall  in  1  request not accepted this cycle.
- i_redirect  in  1  flush the unit and restart fetch.
- i_redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- o_valid  out  1  buffer head valid.
- o_instr  out  32  head instruction word.
- o_pc  out  32  address the head word was fetched from.
- o_error  out  1  head entry carries a bus error.
- i_ready  in  1  consumer accepts the head; a pop happens when o_valid & i_ready.

## Operation
- FSM states and transitions:
  - POST_RESET: entered on reset. Goes to FETCH after one cycle; a redirect in this state loads fetch_pc.
  - FETCH: issues requests.
  - HALTED: entered when an entry with error=1 is enqueued. Leaves only on i_redirect, going to FETCH.
- fetch_pc register:
  - Reset value is RESET_PC.
  - Increments by PC_STEP on each accepted request (mem_c_en & ~mem_stall). Arithmetic is mod 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
  - Loaded with {i_redirect_pc[31:2],2'b00} on i_redirect.
- Issue rule: mem_c_en=1 iff state==FETCH and (count + inflight − pop) < DEPTH.
  - count is the buffer occupancy.
  - inflight is 1 when a request was accepted last cycle and not cancelled.
  - pop is o_valid & i_ready.
- Stall: while mem_stall=1, mem_c_en and mem_addr hold unchanged. Nothing is accepted and fetch_pc does not move.
- At most one accepted request is outstanding; a new request may be issued in the response cycle of the previous one.
- Response cycle: {mem_rdata, mem_error, request address} is written into the buffer tail.
  - If mem_error=1, the entry is stored with error=1, the FSM enters HALTED, and no further requests issue.
- Buffer: circular, DEPTH entries, with read/write pointers of log2(DEPTH) bits that wrap. Head outputs are driven straight from storage (show-ahead).
  - When o_valid=0, o_instr, o_pc and o_error are 0.
  - Push and pop in the same cycle are allowed, including when the buffer is full: the pop frees the slot the push uses.
- Redirect, all cases: buffer cleared (count=0), pending response discarded, FSM goes to FETCH from any state.
  - A request presented in the redirect cycle and accepted (stall=0) has its response discarded.
  - A pop in the redirect cycle completes normally.
  - Redirect with a response arriving in the same cycle: the response is not enqueued.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any outstanding response is ignored.

## Timing
- Reset values:
  - mem_c_en=0, mem_addr=0, mem_b_en=4'b1111.
  - o_valid=0, o_instr=0, o_pc=0, o_error=0.
  - fetch_pc=RESET_PC, state=POST_RESET.
- Cycle 0 after resetn rises: POST_RESET, no request.
- Cycle 1: first request, mem_addr=RESET_PC.
- Latency from request acceptance to o_valid is 2 cycles: response in cycle N+1, o_valid in cycle N+2.
- Throughput with i_ready=1, no stall and DEPTH≥2: one instruction per cycle. With DEPTH=1: one instruction every 2 cycles.
- Redirect in cycle N: the request at the new address appears in cycle N+1. The first new o_valid appears at N+3 at the earliest.

## Test plan
- Reset release, RESET_PC=0x100, i_ready=1, no stall -> requests at 0x100, 0x104, 0x108 on consecutive cycles; o_valid from cycle 3; o_pc sequence 0x100, 0x104, 0x108.
- mem_stall held for 3 cycles on the request at 0x104 -> mem_addr holds 0x104 for 3 cycles; no duplicate and no skipped PC; o_pc stays in order.
- i_ready=0 with DEPTH=2 -> exactly 2 entries buffered and mem_c_en=0; raising i_ready resumes one instruction per cycle with no loss.
- i_redirect to 0x2003 while a response is in flight and the buffer is full -> buffer empties; next request at 0x2000; the discarded word never appears on o_valid.
- mem_error on the response for 0x108 -> entry presented with o_error=1, o_pc=0x108; no requests while HALTED; i_redirect to 0x40 resumes fetch at 0x40.
- Redirect to 0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
